// File: rtl/imm_ext_pipe_if.sv
// Handshake bundle between decode, the immediate extender and the ALU-B mux.
// The producer and consumer sides both attach through the master modport.
interface imm_ext_pipe_if #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [IN_WIDTH-1:0]  imm;
    logic [1:0]           mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] ext_imm;
    logic [1:0]           ext_mode;

    modport master (
        output in_valid, imm, mode, out_ready,
        input  in_ready, out_valid, ext_imm, ext_mode
    );

    modport slave (
        input  in_valid, imm, mode, out_ready,
        output in_ready, out_valid, ext_imm, ext_mode
    );
endinterface

// File: rtl/imm_ext_pipe.sv
// Pipelined immediate extender: sign/zero/upper/branch-offset widening followed
// by a DEPTH-stage elastic valid/ready pipeline with synchronous flush.
module imm_ext_pipe #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 32,
    parameter int DEPTH     = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    imm_ext_pipe_if.slave bus
);
    localparam int EXT = OUT_WIDTH - IN_WIDTH;

    logic [OUT_WIDTH-1:0] sext;
    logic [OUT_WIDTH-1:0] ext_comb;

    logic [DEPTH-1:0]     v;
    logic [OUT_WIDTH-1:0] data [DEPTH];
    logic [1:0]           md   [DEPTH];
    logic [OUT_WIDTH-1:0] din  [DEPTH];
    logic [1:0]           mdin [DEPTH];
    logic [DEPTH:0]       stage_ready;
    logic [DEPTH-1:0]     load;
    logic [DEPTH-1:0]     unload;

    always_comb begin
        sext = {{EXT{bus.imm[IN_WIDTH-1]}}, bus.imm};
        case (bus.mode)
            2'b00:   ext_comb = sext;
            2'b01:   ext_comb = {{EXT{1'b0}}, bus.imm};
            2'b10:   ext_comb = {bus.imm, {EXT{1'b0}}};
            default: ext_comb = {sext[OUT_WIDTH-3:0], 2'b00};
        endcase
    end

    // A stage can take data if it or any stage downstream of it has a hole,
    // or the consumer is draining the last stage.
    always_comb begin
        for (int k = 0; k <= DEPTH; k++) begin
            logic [DEPTH-1:0] mask;
            mask           = {DEPTH{1'b1}} << k;
            stage_ready[k] = bus.out_ready || ((v & mask) != mask);
        end
    end

    always_comb begin
        load    = '0;
        unload  = '0;
        load[0] = bus.in_valid && stage_ready[0];
        for (int k = 1; k < DEPTH; k++) begin
            load[k] = v[k-1] && stage_ready[k];
        end
        for (int k = 0; k < DEPTH; k++) begin
            unload[k] = v[k] && stage_ready[k+1];
        end
    end

    always_comb begin
        din[0]  = ext_comb;
        mdin[0] = bus.mode;
        for (int k = 1; k < DEPTH; k++) begin
            din[k]  = data[k-1];
            mdin[k] = md[k-1];
        end
    end

    // A refill in the same cycle as a drain wins, keeping one item per cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                data[k] <= '0;
                md[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (flush) begin
                    v[k] <= 1'b0;
                end else if (load[k]) begin
                    v[k] <= 1'b1;
                end else if (unload[k]) begin
                    v[k] <= 1'b0;
                end
                if (load[k]) begin
                    data[k] <= din[k];
                    md[k]   <= mdin[k];
                end
            end
        end
    end

    assign bus.in_ready  = stage_ready[0];
    assign bus.out_valid = v[DEPTH-1];
    assign bus.ext_imm   = data[DEPTH-1];
    assign bus.ext_mode  = md[DEPTH-1];
endmodule

// File: tb/tb_imm_ext_pipe.sv
// Scoreboard bench for imm_ext_pipe: the driver queues hand-computed results on
// each accept, and a negedge monitor pops and compares on every output transfer.
module tb_imm_ext_pipe;
    localparam int IW = 16;
    localparam int OW = 32;
    localparam int D  = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;

    imm_ext_pipe_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();

    imm_ext_pipe #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .DEPTH(D)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  m;
    } exp_t;

    exp_t        sb [$];
    int          pop_cycs [$];
    int          checks      = 0;
    int          failures    = 0;
    int          cyc         = 0;
    int          wait_cycles = 0;
    logic        held_valid  = 1'b0;
    logic [31:0] held_d      = '0;
    logic [1:0]  held_m      = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!reset) begin
            held_valid = 1'b0;
        end else begin
            if (held_valid) begin
                chk("stall_hold_valid", bus.out_valid, 1);
                chk("stall_hold_data", bus.ext_imm, held_d);
                chk("stall_hold_mode", bus.ext_mode, held_m);
            end
            if (flush) begin
                sb.delete();
                held_valid = 1'b0;
            end else if (bus.out_valid && bus.out_ready) begin
                chk("output_expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("ext_imm", bus.ext_imm, e.d);
                    chk("ext_mode", bus.ext_mode, e.m);
                    pop_cycs.push_back(cyc);
                end
                held_valid = 1'b0;
            end else if (bus.out_valid) begin
                held_valid = 1'b1;
                held_d     = bus.ext_imm;
                held_m     = bus.ext_mode;
            end else begin
                held_valid = 1'b0;
            end
        end
    end

    task automatic send(input logic [15:0] i, input logic [1:0] m, input logic [31:0] e);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        bus.in_valid = 1'b1;
        bus.imm      = i;
        bus.mode     = m;
        while (!done) begin
            @(negedge clk);
            if (bus.in_ready) begin
                done = 1'b1;
                if (!flush) begin
                    exp_t x;
                    x.d = e;
                    x.m = m;
                    sb.push_back(x);
                end
            end else begin
                wait_cycles++;
                n++;
            end
            @(posedge clk);
            #2;
            if (!done && n > 50) begin
                chk("send_timeout", n, 0);
                done = 1'b1;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic lat_send(input logic [15:0] i, input logic [1:0] m, input logic [31:0] e);
        int n;
        send(i, m, e);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("latency_edges", n, D - 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("drain_empty", sb.size(), 0);
        repeat (2) @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        bus.in_valid  = 1'b0;
        bus.imm       = '0;
        bus.mode      = '0;
        bus.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_ext_imm", bus.ext_imm, 32'h0);
        chk("reset_ext_mode", bus.ext_mode, 0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_out_valid", bus.out_valid, 0);
        chk("idle_ext_imm", bus.ext_imm, 32'h0);
        chk("idle_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #2;

        lat_send(16'h8001, 2'b00, 32'hFFFF_8001);
        drain();
        lat_send(16'h8001, 2'b01, 32'h0000_8001);
        drain();
        lat_send(16'h1234, 2'b10, 32'h1234_0000);
        drain();
        lat_send(16'hFFFF, 2'b11, 32'hFFFF_FFFC);
        drain();
        lat_send(16'h0004, 2'b11, 32'h0000_0010);
        drain();

        wait_cycles = 0;
        base = pop_cycs.size();
        for (int i = 1; i <= 8; i++) begin
            send(16'(i), 2'b00, 32'(i));
        end
        n = 0;
        while (pop_cycs.size() < base + 8 && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("stream_count", pop_cycs.size() - base, 8);
        if (pop_cycs.size() >= base + 8) begin
            chk("stream_consecutive", pop_cycs[base+7] - pop_cycs[base], 7);
        end
        chk("stream_no_backpressure", wait_cycles, 0);
        drain();

        bus.out_ready = 1'b0;
        fork
            begin
                send(16'h0011, 2'b01, 32'h0000_0011);
                send(16'h0022, 2'b01, 32'h0000_0022);
                send(16'h0033, 2'b01, 32'h0000_0033);
                send(16'h0044, 2'b01, 32'h0000_0044);
            end
            begin
                @(posedge clk);
                @(posedge clk);
                #3;
                chk("stall_in_ready", bus.in_ready, 0);
                chk("stall_out_valid", bus.out_valid, 1);
                chk("stall_head", bus.ext_imm, 32'h0000_0011);
                repeat (3) @(posedge clk);
                #2;
                bus.out_ready = 1'b1;
            end
        join
        drain();

        bus.out_ready = 1'b0;
        send(16'h00A0, 2'b00, 32'h0000_00A0);
        send(16'h00B0, 2'b00, 32'h0000_00B0);
        bus.out_ready = 1'b1;
        flush = 1'b1;
        send(16'h00C0, 2'b00, 32'h0000_00C0);
        flush = 1'b0;
        #1;
        chk("flush_out_valid", bus.out_valid, 0);
        chk("flush_in_ready", bus.in_ready, 1);
        lat_send(16'hF00D, 2'b01, 32'h0000_F00D);
        drain();

        bus.out_ready = 1'b0;
        send(16'h0055, 2'b10, 32'h0055_0000);
        send(16'h0066, 2'b11, 32'h0000_0198);
        #1;
        chk("pre_reset_out_valid", bus.out_valid, 1);
        reset = 1'b0;
        sb.delete();
        #1;
        chk("async_reset_out_valid", bus.out_valid, 0);
        chk("async_reset_ext_imm", bus.ext_imm, 32'h0);
        chk("async_reset_ext_mode", bus.ext_mode, 0);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #2;
        bus.out_ready = 1'b1;
        lat_send(16'h7FFF, 2'b00, 32'h0000_7FFF);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
